// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, sequencer
// states, instruction classes and the datapath strobe bundle.
package control_sequencer_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHL  = 5'b01010;
   localparam logic [4:0] OP_ADDI = 5'b01011;
   localparam logic [4:0] OP_ANDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01101;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_NEG  = 5'b10000;
   localparam logic [4:0] OP_NOT  = 5'b10001;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_IN   = 5'b10100;
   localparam logic [4:0] OP_OUT  = 5'b10101;
   localparam logic [4:0] OP_MFHI = 5'b10110;
   localparam logic [4:0] OP_MFLO = 5'b10111;
   localparam logic [4:0] OP_NOP  = 5'b11000;
   localparam logic [4:0] OP_HALT = 5'b11001;

   localparam logic [4:0] ALU_ADD = 5'b00011;

   typedef enum logic [1:0] {
      ST_RESET,
      ST_RUN,
      ST_HALT
   } seq_state_t;

   // Bit positions of the one-hot instruction class vector
   localparam int CL_LD     = 0;
   localparam int CL_LDI    = 1;
   localparam int CL_ST     = 2;
   localparam int CL_RALU   = 3;
   localparam int CL_IMM    = 4;
   localparam int CL_MULDIV = 5;
   localparam int CL_UNARY  = 6;
   localparam int CL_BR     = 7;
   localparam int CL_JR     = 8;
   localparam int CL_IN     = 9;
   localparam int CL_OUT    = 10;
   localparam int CL_MFHI   = 11;
   localparam int CL_MFLO   = 12;
   localparam int CL_NOP    = 13;
   localparam int CL_HALT   = 14;
   localparam int NUM_CLS   = 15;

   typedef struct packed {
      logic pc_in;
      logic pc_out;
      logic inc_pc;
      logic mar_in;
      logic mdr_in;
      logic mdr_out;
      logic rd;
      logic wr;
      logic ir_in;
      logic y_in;
      logic z_in;
      logic zhi_out;
      logic zlo_out;
      logic hi_in;
      logic hi_out;
      logic lo_in;
      logic lo_out;
      logic con_in;
      logic gra;
      logic grb;
      logic grc;
      logic r_in;
      logic r_out;
      logic ba_out;
      logic c_out;
      logic inport_out;
      logic outport_in;
   } strobes_t;

   // Final T-step of each class; nop and halt end with fetch at T2
   function automatic int last_step(input logic [NUM_CLS-1:0] cls);
      int n;
      n = 2;
      if (cls[CL_LD] | cls[CL_ST])                    n = 7;
      if (cls[CL_MULDIV] | cls[CL_BR])                n = 6;
      if (cls[CL_LDI] | cls[CL_RALU] | cls[CL_IMM])   n = 5;
      if (cls[CL_UNARY])                              n = 4;
      if (cls[CL_JR] | cls[CL_IN] | cls[CL_OUT] |
          cls[CL_MFHI] | cls[CL_MFLO])                n = 3;
      return n;
   endfunction

endpackage

// File: rtl/control_sequencer_opcode_class_decoder.sv
// Combinational opcode-to-class decoder; unassigned opcodes fall into the nop class.
module control_sequencer_opcode_class_decoder
   import control_sequencer_pkg::*;
(
   input  logic [4:0]         i_opcode,
   output logic [NUM_CLS-1:0] o_class
);

   always_comb begin
      o_class = '0;
      case (i_opcode)
         OP_LD:   o_class[CL_LD]   = 1'b1;
         OP_LDI:  o_class[CL_LDI]  = 1'b1;
         OP_ST:   o_class[CL_ST]   = 1'b1;
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_ROR, OP_ROL, OP_SHR, OP_SHL:
                  o_class[CL_RALU] = 1'b1;
         OP_ADDI, OP_ANDI, OP_ORI:
                  o_class[CL_IMM]  = 1'b1;
         OP_MUL, OP_DIV:
                  o_class[CL_MULDIV] = 1'b1;
         OP_NEG, OP_NOT:
                  o_class[CL_UNARY]  = 1'b1;
         OP_BR:   o_class[CL_BR]   = 1'b1;
         OP_JR:   o_class[CL_JR]   = 1'b1;
         OP_IN:   o_class[CL_IN]   = 1'b1;
         OP_OUT:  o_class[CL_OUT]  = 1'b1;
         OP_MFHI: o_class[CL_MFHI] = 1'b1;
         OP_MFLO: o_class[CL_MFLO] = 1'b1;
         OP_NOP:  o_class[CL_NOP]  = 1'b1;
         OP_HALT: o_class[CL_HALT] = 1'b1;
         default: o_class[CL_NOP]  = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, class-specific T3-T7, then T0 or HALT.
// All strobes are a combinational decode of state, step, opcode and CON.
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int MAX_T = 8
)(
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Stop,
   input  logic [31:0] IRregister,
   input  logic        CON,
   output logic        PCin,
   output logic        PCout,
   output logic        IncPC,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        Read,
   output logic        write,
   output logic        IRin,
   output logic        Yin,
   output logic        Zin,
   output logic        ZHIout,
   output logic        ZLOout,
   output logic        HIin,
   output logic        HIout,
   output logic        LOin,
   output logic        LOout,
   output logic        CONin,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        Cout,
   output logic        INPORTout,
   output logic        OUTPORTin,
   output logic [4:0]  alu_op,
   output logic        Run
);

   localparam int STEP_W = $clog2(MAX_T);

   seq_state_t         r_state, w_state_nxt;
   logic [STEP_W-1:0]  r_step, w_step_nxt;
   logic               r_stop_pend, w_stop_pend_nxt;
   logic [4:0]         w_opcode;
   logic [NUM_CLS-1:0] w_cls;
   logic               w_addr_cls;
   logic               w_halt_op;
   logic               w_boundary;
   logic               w_unused_ir;
   strobes_t           w_ctl;
   logic [4:0]         w_alu;

   assign w_opcode    = IRregister[31:27];
   assign w_unused_ir = ^IRregister[26:0];

   control_sequencer_opcode_class_decoder u_dec (
      .i_opcode (w_opcode),
      .o_class  (w_cls)
   );

   assign w_addr_cls = w_cls[CL_LD] | w_cls[CL_LDI] | w_cls[CL_ST];
   assign w_halt_op  = w_cls[CL_HALT] && (int'(r_step) == 2);
   assign w_boundary = (int'(r_step) == last_step(w_cls)) || (int'(r_step) == MAX_T - 1);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state     <= ST_RESET;
         r_step      <= '0;
         r_stop_pend <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_step      <= w_step_nxt;
         r_stop_pend <= w_stop_pend_nxt;
      end
   end

   // A Stop pulse seen mid-instruction is remembered until the next boundary
   always_comb begin
      w_state_nxt     = r_state;
      w_step_nxt      = r_step;
      w_stop_pend_nxt = r_stop_pend | Stop;
      case (r_state)
         ST_RESET: begin
            w_state_nxt     = ST_RUN;
            w_step_nxt      = '0;
            w_stop_pend_nxt = 1'b0;
         end
         ST_RUN: begin
            if (w_halt_op) begin
               w_state_nxt     = ST_HALT;
               w_step_nxt      = '0;
               w_stop_pend_nxt = 1'b0;
            end else if (w_boundary) begin
               w_state_nxt     = (Stop || r_stop_pend) ? ST_HALT : ST_RUN;
               w_step_nxt      = '0;
               w_stop_pend_nxt = 1'b0;
            end else begin
               w_step_nxt = r_step + 1'b1;
            end
         end
         ST_HALT: begin
            w_stop_pend_nxt = 1'b0;
         end
         default: begin
            w_state_nxt = ST_RESET;
            w_step_nxt  = '0;
         end
      endcase
   end

   always_comb begin
      w_ctl = '0;
      w_alu = '0;
      if (r_state == ST_RUN) begin
         w_alu = (int'(r_step) < 3 || w_addr_cls || w_cls[CL_BR]) ? ALU_ADD : w_opcode;
         case (int'(r_step))
            0: begin
               w_ctl.pc_out = 1'b1; w_ctl.mar_in = 1'b1;
               w_ctl.inc_pc = 1'b1; w_ctl.z_in   = 1'b1;
            end
            1: begin
               w_ctl.zlo_out = 1'b1; w_ctl.pc_in  = 1'b1;
               w_ctl.rd      = 1'b1; w_ctl.mdr_in = 1'b1;
            end
            2: begin
               w_ctl.mdr_out = 1'b1; w_ctl.ir_in = 1'b1;
            end
            3: begin
               if (w_addr_cls) begin
                  w_ctl.grb = 1'b1; w_ctl.ba_out = 1'b1; w_ctl.y_in = 1'b1;
               end
               if (w_cls[CL_RALU] | w_cls[CL_IMM]) begin
                  w_ctl.grb = 1'b1; w_ctl.r_out = 1'b1; w_ctl.y_in = 1'b1;
               end
               if (w_cls[CL_MULDIV]) begin
                  w_ctl.gra = 1'b1; w_ctl.r_out = 1'b1; w_ctl.y_in = 1'b1;
               end
               if (w_cls[CL_UNARY]) begin
                  w_ctl.grb = 1'b1; w_ctl.r_out = 1'b1; w_ctl.z_in = 1'b1;
               end
               if (w_cls[CL_BR]) begin
                  w_ctl.gra = 1'b1; w_ctl.r_out = 1'b1; w_ctl.con_in = 1'b1;
               end
               if (w_cls[CL_JR]) begin
                  w_ctl.gra = 1'b1; w_ctl.r_out = 1'b1; w_ctl.pc_in = 1'b1;
               end
               if (w_cls[CL_IN]) begin
                  w_ctl.inport_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.r_in = 1'b1;
               end
               if (w_cls[CL_OUT]) begin
                  w_ctl.gra = 1'b1; w_ctl.r_out = 1'b1; w_ctl.outport_in = 1'b1;
               end
               if (w_cls[CL_MFHI]) begin
                  w_ctl.hi_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.r_in = 1'b1;
               end
               if (w_cls[CL_MFLO]) begin
                  w_ctl.lo_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.r_in = 1'b1;
               end
            end
            4: begin
               if (w_addr_cls | w_cls[CL_IMM]) begin
                  w_ctl.c_out = 1'b1; w_ctl.z_in = 1'b1;
               end
               if (w_cls[CL_RALU]) begin
                  w_ctl.grc = 1'b1; w_ctl.r_out = 1'b1; w_ctl.z_in = 1'b1;
               end
               if (w_cls[CL_MULDIV]) begin
                  w_ctl.grb = 1'b1; w_ctl.r_out = 1'b1; w_ctl.z_in = 1'b1;
               end
               if (w_cls[CL_UNARY]) begin
                  w_ctl.zlo_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.r_in = 1'b1;
               end
               if (w_cls[CL_BR]) begin
                  w_ctl.pc_out = 1'b1; w_ctl.y_in = 1'b1;
               end
            end
            5: begin
               if (w_cls[CL_LD] | w_cls[CL_ST]) begin
                  w_ctl.zlo_out = 1'b1; w_ctl.mar_in = 1'b1;
               end
               if (w_cls[CL_LDI] | w_cls[CL_RALU] | w_cls[CL_IMM]) begin
                  w_ctl.zlo_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.r_in = 1'b1;
               end
               if (w_cls[CL_MULDIV]) begin
                  w_ctl.zlo_out = 1'b1; w_ctl.lo_in = 1'b1;
               end
               if (w_cls[CL_BR]) begin
                  w_ctl.c_out = 1'b1; w_ctl.z_in = 1'b1;
               end
            end
            6: begin
               if (w_cls[CL_LD]) begin
                  w_ctl.rd = 1'b1; w_ctl.mdr_in = 1'b1;
               end
               if (w_cls[CL_ST]) begin
                  w_ctl.gra = 1'b1; w_ctl.r_out = 1'b1; w_ctl.mdr_in = 1'b1;
               end
               if (w_cls[CL_MULDIV]) begin
                  w_ctl.zhi_out = 1'b1; w_ctl.hi_in = 1'b1;
               end
               // Branch target is committed on the live CON value of this cycle
               if (w_cls[CL_BR] && CON) begin
                  w_ctl.zlo_out = 1'b1; w_ctl.pc_in = 1'b1;
               end
            end
            7: begin
               if (w_cls[CL_LD]) begin
                  w_ctl.mdr_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.r_in = 1'b1;
               end
               if (w_cls[CL_ST]) begin
                  w_ctl.wr = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign PCin      = w_ctl.pc_in;
   assign PCout     = w_ctl.pc_out;
   assign IncPC     = w_ctl.inc_pc;
   assign MARin     = w_ctl.mar_in;
   assign MDRin     = w_ctl.mdr_in;
   assign MDRout    = w_ctl.mdr_out;
   assign Read      = w_ctl.rd;
   assign write     = w_ctl.wr;
   assign IRin      = w_ctl.ir_in;
   assign Yin       = w_ctl.y_in;
   assign Zin       = w_ctl.z_in;
   assign ZHIout    = w_ctl.zhi_out;
   assign ZLOout    = w_ctl.zlo_out;
   assign HIin      = w_ctl.hi_in;
   assign HIout     = w_ctl.hi_out;
   assign LOin      = w_ctl.lo_in;
   assign LOout     = w_ctl.lo_out;
   assign CONin     = w_ctl.con_in;
   assign Gra       = w_ctl.gra;
   assign Grb       = w_ctl.grb;
   assign Grc       = w_ctl.grc;
   assign Rin       = w_ctl.r_in;
   assign Rout      = w_ctl.r_out;
   assign BAout     = w_ctl.ba_out;
   assign Cout      = w_ctl.c_out;
   assign INPORTout = w_ctl.inport_out;
   assign OUTPORTin = w_ctl.outport_in;
   assign alu_op    = w_alu;
   assign Run       = (r_state == ST_RUN);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch, ld, add, br, mul+Stop, halt and
// illegal opcodes, plus asynchronous reset mid-instruction.
module tb_control_sequencer;
   import control_sequencer_pkg::*;

   logic        Clock = 1'b0;
   logic        Reset, Stop, CON;
   logic [31:0] IRregister;
   logic        PCin, PCout, IncPC, MARin, MDRin, MDRout, Read, write, IRin;
   logic        Yin, Zin, ZHIout, ZLOout, HIin, HIout, LOin, LOout, CONin;
   logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout, INPORTout, OUTPORTin;
   logic [4:0]  alu_op;
   logic        Run;

   int n_chk = 0;
   int n_err = 0;

   control_sequencer #(.MAX_T(8)) dut (
      .Clock(Clock), .Reset(Reset), .Stop(Stop), .IRregister(IRregister), .CON(CON),
      .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .Read(Read), .write(write), .IRin(IRin), .Yin(Yin), .Zin(Zin),
      .ZHIout(ZHIout), .ZLOout(ZLOout), .HIin(HIin), .HIout(HIout), .LOin(LOin),
      .LOout(LOout), .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
      .Rout(Rout), .BAout(BAout), .Cout(Cout), .INPORTout(INPORTout),
      .OUTPORTin(OUTPORTin), .alu_op(alu_op), .Run(Run)
   );

   always #5 Clock = ~Clock;

   logic [26:0] obs;
   logic [9:0]  drv;
   assign obs = {PCin, PCout, IncPC, MARin, MDRin, MDRout, Read, write, IRin,
                 Yin, Zin, ZHIout, ZLOout, HIin, HIout, LOin, LOout, CONin,
                 Gra, Grb, Grc, Rin, Rout, BAout, Cout, INPORTout, OUTPORTin};
   assign drv = {PCout, MDRout, ZHIout, ZLOout, HIout, LOout, Rout, BAout, Cout, INPORTout};

   localparam logic [26:0] S_PCIN   = 27'h1 << 26;
   localparam logic [26:0] S_PCOUT  = 27'h1 << 25;
   localparam logic [26:0] S_INCPC  = 27'h1 << 24;
   localparam logic [26:0] S_MARIN  = 27'h1 << 23;
   localparam logic [26:0] S_MDRIN  = 27'h1 << 22;
   localparam logic [26:0] S_MDROUT = 27'h1 << 21;
   localparam logic [26:0] S_READ   = 27'h1 << 20;
   localparam logic [26:0] S_IRIN   = 27'h1 << 18;
   localparam logic [26:0] S_YIN    = 27'h1 << 17;
   localparam logic [26:0] S_ZIN    = 27'h1 << 16;
   localparam logic [26:0] S_ZHIOUT = 27'h1 << 15;
   localparam logic [26:0] S_ZLOOUT = 27'h1 << 14;
   localparam logic [26:0] S_HIIN   = 27'h1 << 13;
   localparam logic [26:0] S_LOIN   = 27'h1 << 11;
   localparam logic [26:0] S_CONIN  = 27'h1 << 9;
   localparam logic [26:0] S_GRA    = 27'h1 << 8;
   localparam logic [26:0] S_GRB    = 27'h1 << 7;
   localparam logic [26:0] S_GRC    = 27'h1 << 6;
   localparam logic [26:0] S_RIN    = 27'h1 << 5;
   localparam logic [26:0] S_ROUT   = 27'h1 << 4;
   localparam logic [26:0] S_BAOUT  = 27'h1 << 3;
   localparam logic [26:0] S_COUT   = 27'h1 << 2;
   localparam logic [26:0] S_NONE   = 27'h0;

   task automatic cyc();
      @(negedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [26:0] es, input logic [4:0] ea, input logic er);
      #1;
      n_chk++;
      assert ({obs, alu_op, Run} === {es, ea, er}) else begin
         n_err++;
         $error("FAIL %s strobes=%h alu=%b run=%b, expected strobes=%h alu=%b run=%b",
                tag, obs, alu_op, Run, es, ea, er);
      end
      n_chk++;
      assert ($onehot0(drv)) else begin
         n_err++;
         $error("FAIL %s_bus drivers=%b, expected at most one set", tag, drv);
      end
   endtask

   // Checks the current T0 and the following T1, T2; leaves the bench at T3
   task automatic fetch(input string tag);
      chk({tag, "/T0"}, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, ALU_ADD, 1'b1);
      cyc();
      chk({tag, "/T1"}, S_ZLOOUT | S_PCIN | S_READ | S_MDRIN, ALU_ADD, 1'b1);
      cyc();
      chk({tag, "/T2"}, S_MDROUT | S_IRIN, ALU_ADD, 1'b1);
      cyc();
   endtask

   initial begin
      Reset = 1'b1; Stop = 1'b0; CON = 1'b0;
      IRregister = 32'h191A_0000;          // add R2,R3,R4
      cyc();
      chk("reset", S_NONE, 5'b00000, 1'b0);
      Reset = 1'b0;
      cyc();

      fetch("add");
      chk("add/T3", S_GRB | S_ROUT | S_YIN, OP_ADD, 1'b1); cyc();
      chk("add/T4", S_GRC | S_ROUT | S_ZIN, OP_ADD, 1'b1); cyc();
      chk("add/T5", S_ZLOOUT | S_GRA | S_RIN, OP_ADD, 1'b1); cyc();

      // Cycle 6 after T0 must be T0 again; then reset in T5 of this add
      fetch("add2");
      cyc(); cyc();
      chk("add2/T5", S_ZLOOUT | S_GRA | S_RIN, OP_ADD, 1'b1);
      Reset = 1'b1;
      chk("rst_mid", S_NONE, 5'b00000, 1'b0);
      cyc();
      chk("rst_hold", S_NONE, 5'b00000, 1'b0);
      Reset = 1'b0;
      cyc();

      IRregister = 32'h0080_0075;          // ld R1,0x75
      fetch("ld");
      chk("ld/T3", S_GRB | S_BAOUT | S_YIN, ALU_ADD, 1'b1); cyc();
      chk("ld/T4", S_COUT | S_ZIN, ALU_ADD, 1'b1); cyc();
      chk("ld/T5", S_ZLOOUT | S_MARIN, ALU_ADD, 1'b1); cyc();
      chk("ld/T6", S_READ | S_MDRIN, ALU_ADD, 1'b1); cyc();
      chk("ld/T7", S_MDROUT | S_GRA | S_RIN, ALU_ADD, 1'b1); cyc();

      // br, CON high at T3 but low at T6: no PC update
      IRregister = 32'h9000_0000;
      fetch("br0");
      CON = 1'b1;
      chk("br0/T3", S_GRA | S_ROUT | S_CONIN, ALU_ADD, 1'b1); cyc();
      CON = 1'b0;
      chk("br0/T4", S_PCOUT | S_YIN, ALU_ADD, 1'b1); cyc();
      chk("br0/T5", S_COUT | S_ZIN, ALU_ADD, 1'b1); cyc();
      chk("br0/T6", S_NONE, ALU_ADD, 1'b1); cyc();

      // br, CON low at T3 but high at T6: PC update
      fetch("br1");
      chk("br1/T3", S_GRA | S_ROUT | S_CONIN, ALU_ADD, 1'b1); cyc();
      chk("br1/T4", S_PCOUT | S_YIN, ALU_ADD, 1'b1); cyc();
      chk("br1/T5", S_COUT | S_ZIN, ALU_ADD, 1'b1); cyc();
      CON = 1'b1;
      chk("br1/T6", S_ZLOOUT | S_PCIN, ALU_ADD, 1'b1); cyc();
      CON = 1'b0;

      // mul with a one-cycle Stop pulse in T4
      IRregister = 32'h7000_0000;
      fetch("mul");
      chk("mul/T3", S_GRA | S_ROUT | S_YIN, OP_MUL, 1'b1); cyc();
      Stop = 1'b1;
      chk("mul/T4", S_GRB | S_ROUT | S_ZIN, OP_MUL, 1'b1); cyc();
      Stop = 1'b0;
      chk("mul/T5", S_ZLOOUT | S_LOIN, OP_MUL, 1'b1); cyc();
      chk("mul/T6", S_ZHIOUT | S_HIIN, OP_MUL, 1'b1); cyc();
      chk("mul/halt", S_NONE, 5'b00000, 1'b0);
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("mul/halt_hold", S_NONE, 5'b00000, 1'b0);
      end
      Reset = 1'b1;
      cyc();
      Reset = 1'b0;
      cyc();

      // Illegal opcode runs as nop: its successor's T0 follows T2 directly
      IRregister = 32'hF800_0000;
      fetch("illegal");
      IRregister = 32'hC800_0000;          // halt
      fetch("halt");
      chk("halt/enter", S_NONE, 5'b00000, 1'b0);
      cyc();
      chk("halt/stay", S_NONE, 5'b00000, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
